dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
//  Data-memory responder on the processor's dmem port (address_dmem/data/wren, returns q_dmem).
//  Stores enter a DEPTH-entry FIFO and drain to a single-port synchronous RAM when the RAM port is free.
//  Loads are served from the youngest matching buffered store, or from the RAM on a miss.
//  Drives `stall` back to the pipeline when a request cannot be accepted this cycle.
// PARAMETERS
//  DEPTH   4   store-buffer entries; power of 2, >=2
//  ADDR_W  12  word-address bits used; address_dmem[ADDR_W-1:0]
//  DATA_W  32  data word width
// PORTS
//  clock         in   1       master clock; all state updates on posedge
//  reset         in   1       synchronous, active-low reset
//  address_dmem  in   32      word address of the request; only [ADDR_W-1:0] used
//  data          in   DATA_W  store data
//  wren          in   1       store request
//  rden          in   1       load request
//  q_dmem        out  DATA_W  load data, valid the cycle after an accepted load
//  stall         out  1       request not accepted this cycle; requester holds it
//  empty         out  1       buffer holds no stores
//  ram_ready     in   1       RAM accepts a read or write this cycle
//  ram_addr      out  ADDR_W  RAM address
//  ram_wdata     out  DATA_W  RAM write data
//  ram_we        out  1       RAM write strobe
//  ram_re        out  1       RAM read strobe; ram_q valid next cycle
//  ram_q         in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset (reset==0 at posedge): count=0, head=tail=0, all entries invalid, hit_sel=1, hit_data=0.
//   Outputs: q_dmem=0, stall=0, empty=1, ram_we=0, ram_re=0. Pending stores are discarded.
//   A request in flight at reset is dropped.
//  Arbitration: wren and rden both high -> store has priority; the load is ignored, no stall for it.
//  Lookup (rden & !wren): compare addr with all valid entries.
//   hit  = any match; the youngest match (closest to tail) supplies the data.
//   miss = no match.
//  Drain: drain_fire = ram_ready & !empty & !(rden & !wren & miss).
//   On drain_fire: ram_we=1, ram_addr/ram_wdata = head entry; head++ (mod DEPTH); count--.
//  Load miss: ram_re=1, ram_addr=addr when ram_ready; otherwise stall=1, no state change.
//   Load misses take the RAM port over drain in that cycle.
//  Store accept: accept = wren & (count<DEPTH | drain_fire).
//   On accept: write {addr,data} at tail; tail++ (mod DEPTH); count++.
//   Accept and drain in the same cycle leave count unchanged.
//   Accepting a store at the entry being popped in the same cycle is legal.
//  stall = (wren & !accept) | (rden & !wren & miss & !ram_ready). Combinational.
//  Load return (latency 1):
//   hit           -> hit_data<=entry data, hit_sel<=1.
//   accepted miss -> hit_sel<=0.
//   q_dmem = hit_sel ? hit_data : ram_q.
//   q_dmem is defined only the cycle after an accepted load; otherwise it shows the last return path.
//  Ordering: a load always observes every earlier accepted store to the same address.
//   A store accepted in the same cycle as a load is not visible to that load (store wins arbitration).
//  Idle: ram_we/ram_re low whenever no drain or miss fires; ram_addr/ram_wdata are don't-care.
//  empty = (count==0). Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits and never exceeds DEPTH.
// TESTING
//  T1: ram_ready=1, store [5]=0xAAAA then next cycle load [5]
//      -> ram_re=0 that cycle (hit); q_dmem=0xAAAA one cycle later.
//  T2: ram_ready=0, stores [1]=1,[1]=2,[2]=3; then load [1]
//      -> hit on youngest entry, q_dmem=2; stall=0; ram_we=0 throughout.
//  T3: ram_ready=0, 4 stores to [0..3] fill the buffer; 5th store
//      -> stall=1, count=4 held; raise ram_ready -> 5th store accepted and [0] drained in the same cycle, count stays 4.
//  T4: RAM preloaded [9]=0x1234, buffer non-empty, load [9] with ram_ready=1
//      -> ram_re=1, ram_addr=9, no drain that cycle; q_dmem=0x1234 next cycle.
//      With ram_ready=0 the same load gives stall=1 until ready.
//  T5: buffer holds 3 stores; reset=0 one cycle
//      -> empty=1, ram_we=0, q_dmem=0; a following load to a stored address misses to RAM.
//  T6: wren and rden both high -> store accepted, load ignored, ram_re=0.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer: stores queue in a small FIFO and drain to a single-port RAM.
// Loads forward from the youngest matching buffered store, otherwise read the RAM.
module dmem_store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              rden,
    output logic [DATA_W-1:0] q_dmem,
    output logic              stall,
    output logic              empty,
    input  logic              ram_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_hit_sel;
    logic [DATA_W-1:0] r_hit_data;

    logic [ADDR_W-1:0] w_addr;
    logic              w_load;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;
    logic [PTR_W-1:0]  w_idx;
    logic              w_miss;
    logic              w_empty;
    logic              w_drain_fire;
    logic              w_accept;
    logic              w_miss_fire;
    logic              w_unused_addr;

    assign w_addr        = address_dmem[ADDR_W-1:0];
    assign w_unused_addr = ^address_dmem[31:ADDR_W];
    assign w_load        = rden & ~wren;
    assign w_empty       = (r_count == '0);

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PTR_W'(k);
            if ((CNT_W'(k) < r_count) && (r_addr[w_idx] == w_addr)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[w_idx];
            end
        end
    end

    assign w_miss       = w_load & ~w_hit;
    assign w_miss_fire  = w_miss & ram_ready;
    assign w_drain_fire = ram_ready & ~w_empty & ~w_miss;
    assign w_accept     = wren & ((r_count < CNT_W'(DEPTH)) | w_drain_fire);

    // A load miss owns the RAM port; otherwise the head entry drains.
    always_comb begin
        ram_we    = w_drain_fire;
        ram_re    = w_miss_fire;
        ram_addr  = w_miss ? w_addr : r_addr[r_head];
        ram_wdata = r_data[r_head];
    end

    assign stall  = (wren & ~w_accept) | (w_miss & ~ram_ready);
    assign empty  = w_empty;
    assign q_dmem = r_hit_sel ? r_hit_data : ram_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_hit_sel  <= 1'b1;
            r_hit_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr[r_tail] <= w_addr;
                r_data[r_tail] <= data;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_drain_fire) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_drain_fire);
            if (w_load & w_hit) begin
                r_hit_sel  <= 1'b1;
                r_hit_data <= w_hit_data;
            end else if (w_miss_fire) begin
                r_hit_sel <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a one-cycle-latency RAM model.
module tb_dmem_store_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic        rden;
    logic [31:0] q_dmem;
    logic        stall;
    logic        empty;
    logic        ram_ready;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_q;

    logic [31:0] mem [4096];
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  in_bits;   // {reset, ram_ready, wren, rden}
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  exp_bits;  // {stall, empty, ram_we, ram_re}
        logic        chk_q;
        logic [31:0] q;
        logic        chk_a;
        logic [11:0] ra;
    } vec_t;

    vec_t vecs [$];

    dmem_store_buffer #(.DEPTH(4), .ADDR_W(12), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .rden(rden), .q_dmem(q_dmem), .stall(stall), .empty(empty),
        .ram_ready(ram_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_q <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t row(input logic [3:0] ib, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] eb, input logic cq, input logic [31:0] q,
                                 input logic ca, input logic [11:0] ra);
        vec_t v;
        v.in_bits = ib; v.a = a; v.d = d; v.exp_bits = eb;
        v.chk_q = cq; v.q = q; v.chk_a = ca; v.ra = ra;
        return v;
    endfunction

    task automatic drive(input logic rr, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        ram_ready = rr; wren = we; rden = re; address_dmem = a; data = d;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[9] = 32'h1234;
        mem[7] = 32'h7e7e;
        ram_q = 32'h0;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clock);

        // Rows: outputs sampled before the edge; q_dmem reflects the previous row's load.
        vecs.push_back(row(4'b1100, 32'd0, 32'h0,     4'b0100, 1'b1, 32'h0,     1'b0, 12'd0)); // reset state
        vecs.push_back(row(4'b1110, 32'd5, 32'hAAAA,  4'b0100, 1'b0, 32'h0,     1'b0, 12'd0)); // T1 store
        vecs.push_back(row(4'b1101, 32'd5, 32'h0,     4'b0010, 1'b0, 32'h0,     1'b1, 12'd5)); // T1 hit + drain
        vecs.push_back(row(4'b1100, 32'd0, 32'h0,     4'b0100, 1'b1, 32'hAAAA,  1'b0, 12'd0));
        vecs.push_back(row(4'b1010, 32'd1, 32'h1,     4'b0100, 1'b0, 32'h0,     1'b0, 12'd0)); // T2
        vecs.push_back(row(4'b1010, 32'd1, 32'h2,     4'b0000, 1'b0, 32'h0,     1'b0, 12'd0));
        vecs.push_back(row(4'b1010, 32'd2, 32'h3,     4'b0000, 1'b0, 32'h0,     1'b0, 12'd0));
        vecs.push_back(row(4'b1001, 32'd1, 32'h0,     4'b0000, 1'b0, 32'h0,     1'b0, 12'd0));
        vecs.push_back(row(4'b1000, 32'd0, 32'h0,     4'b0000, 1'b1, 32'h2,     1'b0, 12'd0));
        vecs.push_back(row(4'b1011, 32'd7, 32'h77,    4'b0000, 1'b0, 32'h0,     1'b0, 12'd0)); // T6
        vecs.push_back(row(4'b1010, 32'd8, 32'h88,    4'b1000, 1'b0, 32'h0,     1'b0, 12'd0)); // full
        vecs.push_back(row(4'b1110, 32'd8, 32'h88,    4'b0010, 1'b0, 32'h0,     1'b1, 12'd1)); // accept+drain
        vecs.push_back(row(4'b1001, 32'd7, 32'h0,     4'b0000, 1'b0, 32'h0,     1'b0, 12'd0)); // T6 store visible
        vecs.push_back(row(4'b1001, 32'd9, 32'h0,     4'b1000, 1'b0, 32'h0,     1'b0, 12'd0)); // T4 not ready
        vecs.push_back(row(4'b1101, 32'd9, 32'h0,     4'b0001, 1'b1, 32'h77,    1'b1, 12'd9)); // T4 miss
        vecs.push_back(row(4'b1000, 32'd0, 32'h0,     4'b0000, 1'b1, 32'h1234,  1'b0, 12'd0));
        vecs.push_back(row(4'b1101, 32'd1, 32'h0,     4'b0010, 1'b0, 32'h0,     1'b1, 12'd1)); // hit beats stale RAM
        vecs.push_back(row(4'b1000, 32'd0, 32'h0,     4'b0000, 1'b1, 32'h2,     1'b0, 12'd0));
        vecs.push_back(row(4'b0000, 32'd0, 32'h0,     4'b0000, 1'b0, 32'h0,     1'b0, 12'd0)); // T5 reset
        vecs.push_back(row(4'b1100, 32'd0, 32'h0,     4'b0100, 1'b1, 32'h0,     1'b0, 12'd0));
        vecs.push_back(row(4'b1101, 32'd7, 32'h0,     4'b0101, 1'b0, 32'h0,     1'b1, 12'd7));
        vecs.push_back(row(4'b1100, 32'd0, 32'h0,     4'b0100, 1'b1, 32'h7e7e,  1'b0, 12'd0));

        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].in_bits[3];
            drive(vecs[i].in_bits[2], vecs[i].in_bits[1], vecs[i].in_bits[0], vecs[i].a, vecs[i].d);
            #1;
            check($sformatf("v%0d.stall", i),  32'(stall),  32'(vecs[i].exp_bits[3]));
            check($sformatf("v%0d.empty", i),  32'(empty),  32'(vecs[i].exp_bits[2]));
            check($sformatf("v%0d.ram_we", i), 32'(ram_we), 32'(vecs[i].exp_bits[1]));
            check($sformatf("v%0d.ram_re", i), 32'(ram_re), 32'(vecs[i].exp_bits[0]));
            if (vecs[i].chk_q) check($sformatf("v%0d.q_dmem", i), q_dmem, vecs[i].q);
            if (vecs[i].chk_a) check($sformatf("v%0d.ram_addr", i), 32'(ram_addr), 32'(vecs[i].ra));
            @(posedge clock);
        end

        // T3: fill with RAM busy, fifth store stalls, then accept and drain together.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive(1'b0, 1'b1, 1'b0, 32'(k), 32'h10 + 32'(k));
            #1;
            check($sformatf("t3.fill%0d.stall", k), 32'(stall), 32'h0);
            @(posedge clock);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            drive(1'b0, 1'b1, 1'b0, 32'd4, 32'h14);
            #1;
            check($sformatf("t3.full%0d.stall", k), 32'(stall), 32'h1);
            check($sformatf("t3.full%0d.ram_we", k), 32'(ram_we), 32'h0);
            @(posedge clock);
        end
        @(negedge clock);
        drive(1'b1, 1'b1, 1'b0, 32'd4, 32'h14);
        #1;
        check("t3.accept.stall", 32'(stall), 32'h0);
        check("t3.accept.ram_we", 32'(ram_we), 32'h1);
        check("t3.accept.ram_addr", 32'(ram_addr), 32'h0);
        check("t3.accept.ram_wdata", ram_wdata, 32'h10);
        @(posedge clock);
        // Four more drains prove count stayed at 4 and the tail wrapped.
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            check($sformatf("t3.drain%0d.ram_we", k), 32'(ram_we), 32'h1);
            check($sformatf("t3.drain%0d.ram_addr", k), 32'(ram_addr), 32'(k));
            check($sformatf("t3.drain%0d.ram_wdata", k), ram_wdata, 32'h10 + 32'(k));
            check($sformatf("t3.drain%0d.empty", k), 32'(empty), 32'h0);
            @(posedge clock);
        end
        @(negedge clock);
        drive(1'b1, 1'b0, 1'b1, 32'd4, 32'h0);
        #1;
        check("t3.done.empty", 32'(empty), 32'h1);
        check("t3.load.ram_re", 32'(ram_re), 32'h1);
        check("t3.load.ram_we", 32'(ram_we), 32'h0);
        @(posedge clock);
        @(negedge clock);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("t3.load.q_dmem", q_dmem, 32'h14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
